// File: rtl/alu_req_scheduler.sv
// rtl/alu_req_scheduler.sv - two-requester round-robin scheduler for a shared 4-bit ALU
// Optional per-requester completion counters are enabled with ALU_SCHED_STATS_EN.
module alu_req_scheduler #(
  parameter int ALU_LAT = 1,
  parameter int STAT_W  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_op,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_op,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       alu_en,
  output logic [3:0] alu_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [7:0] alu_result,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_id,
  output logic [7:0] resp_data,
  output logic       resp_err
`ifdef ALU_SCHED_STATS_EN
  ,
  output logic [STAT_W-1:0] cnt0,
  output logic [STAT_W-1:0] cnt1
`endif
);

  if (ALU_LAT < 1 || ALU_LAT > 7) begin : g_bad_lat
    $error("alu_req_scheduler: ALU_LAT must be 1..7");
  end
  if (STAT_W < 1) begin : g_bad_statw
    $error("alu_req_scheduler: STAT_W must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [2:0] LAST = 3'(ALU_LAT - 1);

  state_t     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic [2:0] wait_q, wait_d;
  logic       alu_en_q, alu_en_d;
  logic [3:0] alu_op_q, alu_op_d;
  logic [3:0] alu_a_q, alu_a_d;
  logic [3:0] alu_b_q, alu_b_d;
  logic       resp_valid_q, resp_valid_d;
  logic       resp_id_q, resp_id_d;
  logic [7:0] resp_data_q, resp_data_d;
  logic       resp_err_q, resp_err_d;

  logic       gnt0, gnt1, accept, illegal;
  logic [3:0] sel_op, sel_a, sel_b;

  // Ties go to the requester that did not win last time.
  always_comb begin
    gnt0    = req0_valid && (!req1_valid || last_grant_q);
    gnt1    = req1_valid && (!req0_valid || !last_grant_q);
    sel_op  = gnt1 ? req1_op : req0_op;
    sel_a   = gnt1 ? req1_a  : req0_a;
    sel_b   = gnt1 ? req1_b  : req0_b;
    illegal = (sel_op > 4'hC) || (sel_op == 4'h3 && sel_b == 4'h0);
    accept  = (state_q == IDLE) && !rst && (gnt0 || gnt1);
  end

  assign req0_ready = (state_q == IDLE) && !rst && gnt0;
  assign req1_ready = (state_q == IDLE) && !rst && gnt1;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wait_d       = wait_q;
    alu_en_d     = alu_en_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          last_grant_d = gnt1;
          resp_id_d    = gnt1;
          if (illegal) begin
            // Rejected commands never reach the ALU, so its operands keep their old values.
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_data_d  = 8'h00;
          end else begin
            state_d  = EXEC;
            wait_d   = 3'd0;
            alu_en_d = 1'b1;
            alu_op_d = sel_op;
            alu_a_d  = sel_a;
            alu_b_d  = sel_b;
          end
        end
      end
      EXEC: begin
        wait_d = wait_q + 3'd1;
        if (wait_q == LAST) begin
          state_d      = RESP;
          alu_en_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_data_d  = alu_result;
          resp_err_d   = 1'b0;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      wait_q       <= 3'd0;
      alu_en_q     <= 1'b0;
      alu_op_q     <= 4'h0;
      alu_a_q      <= 4'h0;
      alu_b_q      <= 4'h0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= 8'h00;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wait_q       <= wait_d;
      alu_en_q     <= alu_en_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign alu_en     = alu_en_q;
  assign alu_op     = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

`ifdef ALU_SCHED_STATS_EN
  logic [STAT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // Errored responses count too; counters stick at all-ones.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (resp_valid_q && resp_ready) begin
      if (!resp_id_q && cnt0_q != '1) cnt0_d = cnt0_q + 1'b1;
      if (resp_id_q && cnt1_q != '1)  cnt1_d = cnt1_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_req_scheduler.sv
// tb/tb_alu_req_scheduler.sv - directed and randomized checks of alu_req_scheduler against a transaction model
module tb_alu_req_scheduler;

  localparam int LAT    = 1;
  localparam int LAT3   = 3;
  localparam int STAT_W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       r0v, r1v, r0rdy, r1rdy;
  logic [3:0] r0op, r0a, r0b, r1op, r1a, r1b;
  logic       alu_en;
  logic [3:0] alu_op, alu_a, alu_b;
  logic [7:0] alu_result;
  logic       resp_valid, resp_ready, resp_id, resp_err;
  logic [7:0] resp_data;

  logic       s_r0v, s_r1v, s_r0rdy, s_r1rdy;
  logic [3:0] s_r0op, s_r0a, s_r0b, s_r1op, s_r1a, s_r1b;
  logic       s_en;
  logic [3:0] s_op, s_a, s_b;
  logic [7:0] s_res;
  logic       s_rv, s_rr, s_id, s_err;
  logic [7:0] s_data;

`ifdef ALU_SCHED_STATS_EN
  logic [STAT_W-1:0] cnt0, cnt1, s_cnt0, s_cnt1;
`endif

  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [7:0] x, y;
    x = {4'h0, a};
    y = {4'h0, b};
    case (op)
      4'h0: return x + y;
      4'h1: return x - y;
      4'h2: return x * y;
      4'h3: return (b == 4'h0) ? 8'hFF : x / y;
      4'h4: return x & y;
      4'h5: return x | y;
      4'h6: return x ^ y;
      4'h7: return {4'h0, ~a};
      4'h8: return x * x;
      4'h9: return x << b[1:0];
      4'hA: return x >> b[1:0];
      4'hB: return x + 8'd1;
      4'hC: return x - 8'd1;
      default: return 8'hEE;
    endcase
  endfunction

  assign alu_result = alu_f(alu_op, alu_a, alu_b);
  assign s_res      = alu_f(s_op, s_a, s_b);

  alu_req_scheduler #(.ALU_LAT(LAT), .STAT_W(STAT_W)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_ready(r0rdy), .req0_op(r0op), .req0_a(r0a), .req0_b(r0b),
    .req1_valid(r1v), .req1_ready(r1rdy), .req1_op(r1op), .req1_a(r1a), .req1_b(r1b),
    .alu_en(alu_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_err(resp_err)
`ifdef ALU_SCHED_STATS_EN
    , .cnt0(cnt0), .cnt1(cnt1)
`endif
  );

  alu_req_scheduler #(.ALU_LAT(LAT3), .STAT_W(STAT_W)) u_lat3 (
    .clk(clk), .rst(rst),
    .req0_valid(s_r0v), .req0_ready(s_r0rdy), .req0_op(s_r0op), .req0_a(s_r0a), .req0_b(s_r0b),
    .req1_valid(s_r1v), .req1_ready(s_r1rdy), .req1_op(s_r1op), .req1_a(s_r1a), .req1_b(s_r1b),
    .alu_en(s_en), .alu_op(s_op), .alu_a(s_a), .alu_b(s_b), .alu_result(s_res),
    .resp_valid(s_rv), .resp_ready(s_rr), .resp_id(s_id),
    .resp_data(s_data), .resp_err(s_err)
`ifdef ALU_SCHED_STATS_EN
    , .cnt0(s_cnt0), .cnt1(s_cnt1)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic bound_expired(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model of the main instance: one command in flight at a time.
  int         cyc = 0;
  bit         busy = 0, last_g = 1, m_legal = 0, hs0 = 0, hs1 = 0;
  int         acc_cyc = 0, due = 0, m_cnt0 = 0, m_cnt1 = 0;
  logic       m_id = 0, m_err = 0;
  logic [7:0] m_data = 0;
  logic [3:0] m_op = 0, m_a = 0, m_b = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : model
    bit g0, g1, e0, e1, erv, een, take1;
    logic [3:0] op, a, b;
    if (cyc >= 1) begin
      g0  = r0v && (!r1v || last_g);
      g1  = r1v && (!r0v || !last_g);
      e0  = !busy && !rst && g0;
      e1  = !busy && !rst && g1;
      erv = busy && (cyc >= due);
      een = busy && m_legal && (cyc > acc_cyc) && (cyc <= acc_cyc + LAT);
      chk("req0_ready", r0rdy, e0);
      chk("req1_ready", r1rdy, e1);
      chk("resp_valid", resp_valid, erv);
      chk("alu_en", alu_en, een);
      chk("alu_op", alu_op, m_op);
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      if (erv) begin
        chk("resp_id", resp_id, m_id);
        chk("resp_data", resp_data, m_data);
        chk("resp_err", resp_err, m_err);
      end
`ifdef ALU_SCHED_STATS_EN
      chk("cnt0", cnt0, m_cnt0);
      chk("cnt1", cnt1, m_cnt1);
`endif
      hs0 = e0 && r0v;
      hs1 = e1 && r1v;
      if (rst) begin
        busy = 0; last_g = 1; m_op = 0; m_a = 0; m_b = 0; m_cnt0 = 0; m_cnt1 = 0;
      end else if (erv && resp_ready) begin
        busy = 0;
        if (!m_id && m_cnt0 < (1 << STAT_W) - 1) m_cnt0++;
        if (m_id && m_cnt1 < (1 << STAT_W) - 1)  m_cnt1++;
      end else if (hs0 || hs1) begin
        take1   = hs1;
        op      = take1 ? r1op : r0op;
        a       = take1 ? r1a : r0a;
        b       = take1 ? r1b : r0b;
        m_legal = !(op > 4'hC || (op == 4'h3 && b == 4'h0));
        busy    = 1;
        last_g  = take1;
        m_id    = take1;
        acc_cyc = cyc;
        due     = m_legal ? cyc + 1 + LAT : cyc + 1;
        m_data  = m_legal ? alu_f(op, a, b) : 8'h00;
        m_err   = !m_legal;
        if (m_legal) begin
          m_op = op; m_a = a; m_b = b;
        end
      end
    end
  end

  task automatic rand_cmd(output logic [3:0] op, output logic [3:0] a, output logic [3:0] b);
    op = 4'($urandom_range(0, 15));
    a  = 4'($urandom_range(0, 15));
    b  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
  endtask

  task automatic send0(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    bit ok;
    r0op = op; r0a = a; r0b = b; r0v = 1'b1; resp_ready = 1'b1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = r0rdy;
      step();
    end
    r0v = 1'b0;
    if (!ok) bound_expired("send0_accept");
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = resp_valid;
      step();
    end
    if (!ok) bound_expired("send0_resp");
  endtask

  initial begin : stim
    logic       ids[4];
    logic [7:0] dat[4];
    int         n;
    rst = 1'b1; resp_ready = 1'b0;
    r0v = 0; r1v = 0; r0op = 0; r0a = 0; r0b = 0; r1op = 0; r1a = 0; r1b = 0;
    s_r0v = 0; s_r1v = 0; s_r0op = 0; s_r0a = 0; s_r0b = 0; s_r1op = 0; s_r1a = 0; s_r1b = 0;
    s_rr = 1'b0;
    step(); step();
    @(negedge clk);
    chk("rst_alu_en", alu_en, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_data", resp_data, 8'h00);
    chk("rst_alu_op", alu_op, 4'h0);
    step();
    rst = 1'b0;

    // Single add: 5 + 9
    r0v = 1; r0op = 4'h0; r0a = 4'd5; r0b = 4'd9; resp_ready = 1;
    @(negedge clk); chk("add_ready_T", r0rdy, 1'b1);
    step(); r0v = 0;
    @(negedge clk); chk("add_alu_en_T1", alu_en, 1'b1); chk("add_rv_T1", resp_valid, 1'b0);
    step();
    @(negedge clk);
    chk("add_alu_en_T2", alu_en, 1'b0);
    chk("add_rv_T2", resp_valid, 1'b1);
    chk("add_id", resp_id, 1'b0);
    chk("add_data", resp_data, 8'd14);
    chk("add_err", resp_err, 1'b0);
    step();

    // Contention from reset: 3*4 and F&6
    rst = 1; step(); rst = 0;
    r0v = 1; r0op = 4'h2; r0a = 4'd3; r0b = 4'd4;
    r1v = 1; r1op = 4'h4; r1a = 4'hF; r1b = 4'h6;
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (resp_valid && resp_ready) begin
        ids[n] = resp_id; dat[n] = resp_data; n++;
      end
      step();
    end
    r0v = 0; r1v = 0;
    if (n < 4) bound_expired("contention");
    else begin
      chk("cont_id0", ids[0], 1'b0); chk("cont_d0", dat[0], 8'd12);
      chk("cont_id1", ids[1], 1'b1); chk("cont_d1", dat[1], 8'd6);
      chk("cont_id2", ids[2], 1'b0); chk("cont_d2", dat[2], 8'd12);
      chk("cont_id3", ids[3], 1'b1); chk("cont_d3", dat[3], 8'd6);
    end

    // Rejections: divide by zero, then an out-of-range opcode
    for (int k = 0; k < 2; k++) begin
      r1v = 1; r1op = (k == 0) ? 4'h3 : 4'hE; r1a = 4'd7; r1b = (k == 0) ? 4'd0 : 4'd3;
      @(negedge clk); chk("rej_ready", r1rdy, 1'b1);
      step(); r1v = 0;
      @(negedge clk);
      chk("rej_rv", resp_valid, 1'b1);
      chk("rej_err", resp_err, 1'b1);
      chk("rej_data", resp_data, 8'h00);
      chk("rej_id", resp_id, 1'b1);
      chk("rej_alu_en", alu_en, 1'b0);
      step();
    end

    // ALU_LAT=3 instance: backpressure, resume, then reset in the second EXEC cycle
    s_r0v = 1; s_r0op = 4'h8; s_r0a = 4'hF; s_r0b = 4'hF;
    s_r1v = 1; s_r1op = 4'h0; s_r1a = 4'd1; s_r1b = 4'd1;
    @(negedge clk); chk("bp_r0_ready", s_r0rdy, 1'b1); chk("bp_r1_ready", s_r1rdy, 1'b0);
    step(); s_r0v = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_exec_en", s_en, 1'b1); chk("bp_exec_rv", s_rv, 1'b0); chk("bp_exec_r1", s_r1rdy, 1'b0);
      step();
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_rv", s_rv, 1'b1); chk("bp_hold_data", s_data, 8'd225);
      chk("bp_hold_r1", s_r1rdy, 1'b0); chk("bp_hold_en", s_en, 1'b0);
      step();
    end
    s_rr = 1;
    @(negedge clk); chk("bp_hs_rv", s_rv, 1'b1);
    step();
    @(negedge clk); chk("bp_resume_r1", s_r1rdy, 1'b1); chk("bp_resume_rv", s_rv, 1'b0);
    step(); s_r1v = 0;
    @(negedge clk); chk("mid_exec1_en", s_en, 1'b1);
    step(); rst = 1;
    @(negedge clk); chk("mid_exec2_en", s_en, 1'b1);
    step(); rst = 0;
    @(negedge clk);
    chk("mid_rst_en", s_en, 1'b0); chk("mid_rst_rv", s_rv, 1'b0);
    chk("mid_rst_op", s_op, 4'h0); chk("mid_rst_a", s_a, 4'h0);
    chk("mid_rst_data", s_data, 8'h00); chk("mid_rst_id", s_id, 1'b0);
    chk("mid_rst_r0", s_r0rdy, 1'b0); chk("mid_rst_r1", s_r1rdy, 1'b0);
    step(); s_r0v = 1; s_r1v = 1;
    @(negedge clk); chk("mid_rst_win0", s_r0rdy, 1'b1); chk("mid_rst_lose1", s_r1rdy, 1'b0);
    step(); s_r0v = 0; s_r1v = 0;

`ifdef ALU_SCHED_STATS_EN
    rst = 1; step(); rst = 0;
    for (int k = 0; k < 5; k++) begin
      send0(4'h0, 4'd1, 4'd1);
      @(negedge clk);
      chk("stat_cnt0", cnt0, (k < 3) ? k + 1 : 3);
      chk("stat_cnt1", cnt1, 0);
    end
    step();
`else
    send0(4'h1, 4'd9, 4'd2);
`endif

    // Randomized traffic with withdrawals, backpressure and occasional reset
    repeat (3000) begin
      step();
      rst        = ($urandom_range(0, 149) == 0);
      resp_ready = ($urandom_range(0, 3) != 0);
      if (r0v && !hs0) begin
        if ($urandom_range(0, 15) == 0) r0v = 0;
      end else begin
        r0v = ($urandom_range(0, 2) != 0);
        rand_cmd(r0op, r0a, r0b);
      end
      if (r1v && !hs1) begin
        if ($urandom_range(0, 15) == 0) r1v = 0;
      end else begin
        r1v = ($urandom_range(0, 2) != 0);
        rand_cmd(r1op, r1a, r1b);
      end
    end
    rst = 0; r0v = 0; r1v = 0; resp_ready = 1;
    repeat (10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_req_scheduler.md
Name: alu_req_scheduler

Overview:
- Shares one 4-bit ALU (13 opcodes, 8-bit result, combinational or registered) between two requesters.
- Round-robin arbitration, operand/opcode holding registers, a wait counter for ALU latency, and a response channel with backpressure.
- Screens illegal opcodes and divide-by-zero before issue.
- Sits between the command sources and the ALU instance in the top-level wrapper.

Parameters:
- ALU_LAT, 1, cycles operands are held on the ALU before the result is sampled; legal range 1..7.
- STAT_W, 8, width of the optional per-requester completion counters.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- req0_valid  in  1  requester 0 command valid
- req0_ready  out  1  requester 0 command accepted this cycle
- req0_op  in  4  requester 0 opcode
- req0_a  in  4  requester 0 operand A
- req0_b  in  4  requester 0 operand B
- req1_valid, req1_ready, req1_op, req1_a, req1_b  as requester 0, for requester 1
- alu_en  out  1  high while a command is executing on the ALU
- alu_op  out  4  opcode driven to the ALU
- alu_a  out  4  operand A driven to the ALU
- alu_b  out  4  operand B driven to the ALU
- alu_result  in  8  ALU result
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumer ready
- resp_id  out  1  requester that issued the command
- resp_data  out  8  captured ALU result
- resp_err  out  1  command rejected (illegal opcode or divide by zero)

Behaviour:
- Clock and reset: one clock `clk`. `rst` is synchronous and active-high.
- Reset values: every output is 0. FSM goes to IDLE. Holding registers are cleared. last_grant = 1, so requester 0 wins first.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready is combinational: high only in IDLE and only for the granted requester.
  - Both ready signals are never high together.
  - Grant: if only one req valid, grant it. If both valid, grant the one != last_grant.
  - On handshake: latch op/a/b into holding registers, latch the id, update last_grant.
  - Legal command: go to EXEC with wait counter = 0.
  - Illegal command: opcode > 4'b1100, or opcode 4'b0011 with b == 0. Go directly to RESP with resp_err = 1, resp_data = 8'h00. The ALU is not issued.
- EXEC:
  - alu_en = 1. alu_op/a/b come from the holding registers and are stable for the whole state.
  - Counter increments each cycle. On the cycle the counter == ALU_LAT-1, sample alu_result into resp_data, set resp_err = 0, go to RESP.
  - Outside EXEC, alu_en = 0; alu_op/a/b hold their last values.
- RESP:
  - resp_valid = 1. resp_id, resp_data and resp_err are stable until the handshake.
  - resp_valid && resp_ready: go to IDLE. The next command may be accepted on the following cycle.
  - resp_ready low: hold indefinitely. No new command is accepted.
- Latency:
  - Legal command accepted at edge T: resp_valid is first high in cycle T+1+ALU_LAT.
  - Rejected command: resp_valid in cycle T+1.
  - Throughput: one command per ALU_LAT+2 cycles with resp_ready held high.
- Requests are held by the requester until accepted. Deasserting valid before ready is permitted; no command is latched in that case.
- Reset mid-operation (EXEC or RESP): the in-flight command is dropped, no response is produced, and state returns to reset values on the next edge.
- Fairness: with both requesters continuously valid, grants strictly alternate 0, 1, 0, 1, ...

Optional Feature:
- Macro: ALU_SCHED_STATS_EN.
- Defined:
  - Adds outputs cnt0 and cnt1 [STAT_W-1:0].
  - Each counts completed response handshakes for its requester, including errored ones.
  - Counters saturate at all-ones and clear on rst.
- Undefined: the ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Single add, ALU_LAT=1: rst, then req0 op=0000 a=5 b=9, resp_ready=1, ALU model returns 8'd14. Expect req0_ready at T; alu_en high in cycle T+1 only; resp_valid at T+2 with resp_id=0, resp_data=14, resp_err=0.
- Contention: req0 and req1 both valid continuously, ops 0010 (3*4) and 0100 (F&6). Expect grant order 0, 1, 0, 1 with resp_data 12, 6, 12, 6.
- Divide by zero: req1 op=0011 a=7 b=0. Expect resp_valid at T+1, resp_err=1, resp_data=0, alu_en never asserted. Same response for op=1110.
- Backpressure, ALU_LAT=3: req0 op=1000 a=15, resp_ready low for 5 cycles. Expect resp_valid held with resp_data=225; req ready low throughout; accept resumes the cycle after the handshake.
- Reset mid-EXEC: assert rst in the second EXEC cycle. Expect all outputs 0 next cycle, no response, and requester 0 wins the next contention.
- With ALU_SCHED_STATS_EN, STAT_W=2: 5 responses to req0. Expect cnt0 = 1, 2, 3, 3, 3 and cnt1 = 0.
